// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the rv_mem instruction/data memory.
// The optional wait-state build is selected with the RV_MEM_WAIT_EN macro.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          WAIT_CYCLES_DEF = 2;

    // Misaligned or beyond the last word of the array.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= words);
    endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Single-port word-addressed RAM: byte-enable write, registered read.
// Contents are intentionally not reset.
module rv_mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // One access per enabled edge: byte-masked write or registered read.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_mem.sv
// Shared instruction/data memory with round-robin arbitration between the
// two request ports. Optional wait states are compiled in with RV_MEM_WAIT_EN.
module rv_mem
    import rv_mem_pkg::*;
#(
    parameter int DPWIDTH     = 32,
    parameter int MEMWORDS    = 1024,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_req,
    input  logic [DPWIDTH-1:0] imem_addr,
    output logic [DPWIDTH-1:0] imem_rdata,
    output logic               imem_ready,
    input  logic               dmem_req,
    input  logic               dmem_we,
    input  logic [3:0]         dmem_be,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_wdata,
    output logic [DPWIDTH-1:0] dmem_rdata,
    output logic               dmem_ready,
    output logic               dmem_err
);

    localparam int AW = $clog2(MEMWORDS);

    state_e       state_q, state_d;
    port_e        port_q, port_d;
    port_e        last_q, last_d;
    port_e        gnt;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   be_q, be_d;
    logic         we_q, we_d;
    logic         err_q, err_d;
    logic         acc_en;
    logic [31:0]  arr_rdata;
    logic [31:0]  ihold_q, dhold_q;
    logic         resp_i, resp_d;
`ifdef RV_MEM_WAIT_EN
    logic [3:0]   cnt_q, cnt_d;
`endif

    // Arbitration: on a conflict the port that did not win last time wins.
    always_comb begin
        gnt = PORT_I;
        if (imem_req && dmem_req) begin
            gnt = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else if (dmem_req) begin
            gnt = PORT_D;
        end
    end

    // Next-state and request latch; acc_en marks the edge entering RESP.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        err_d   = err_q;
        acc_en  = 1'b0;
`ifdef RV_MEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (imem_req || dmem_req) begin
                    port_d = gnt;
                    last_d = gnt;
                    if (gnt == PORT_D) begin
                        addr_d  = dmem_addr;
                        we_d    = dmem_we;
                        be_d    = dmem_be;
                        wdata_d = dmem_wdata;
                    end else begin
                        addr_d  = imem_addr;
                        we_d    = 1'b0;
                        be_d    = 4'h0;
                        wdata_d = '0;
                    end
                    err_d = addr_err(addr_d, 32'(MEMWORDS));
`ifdef RV_MEM_WAIT_EN
                    state_d = S_WAIT;
                    cnt_d   = 4'd0;
`else
                    state_d = S_RESP;
                    acc_en  = 1'b1;
`endif
                end
            end
`ifdef RV_MEM_WAIT_EN
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            port_q  <= PORT_I;
            last_q  <= PORT_I;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef RV_MEM_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef RV_MEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Array sees the values that are valid on the edge entering RESP; an
    // erroring access or an edge under reset never touches it.
    rv_mem_array #(.WORDS(MEMWORDS), .AW(AW)) u_array (
        .clk     (clk),
        .en_i    (acc_en & ~rst),
        .we_i    (we_d & ~err_d),
        .be_i    (be_d),
        .addr_i  (addr_d[AW+1:2]),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    assign resp_i = (state_q == S_RESP) && (port_q == PORT_I);
    assign resp_d = (state_q == S_RESP) && (port_q == PORT_D);

    // Response data: live during RESP, held afterwards. Data writes leave
    // the held read data alone.
    assign imem_rdata = resp_i ? (err_q ? NOP_INSTR : arr_rdata) : ihold_q;
    assign dmem_rdata = resp_d ? (err_q ? '0 : (we_q ? dhold_q : arr_rdata)) : dhold_q;
    assign imem_ready = resp_i;
    assign dmem_ready = resp_d;
    assign dmem_err   = resp_d & err_q;

    // Capture the presented response so rdata holds until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ihold_q <= '0;
            dhold_q <= '0;
        end else begin
            if (resp_i) ihold_q <= imem_rdata;
            if (resp_d) dhold_q <= dmem_rdata;
        end
    end

endmodule

// File: tb/tb_rv_mem.sv
// Self-checking bench for rv_mem: directed scenarios with literal
// expectations plus randomized two-port traffic against a transaction model.
// Build with RV_MEM_WAIT_EN defined to exercise the wait-state variant.
module tb_rv_mem;

    localparam int MW = 64;
    localparam int WC = 3;
`ifdef RV_MEM_WAIT_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req = 1'b0, dmem_req = 1'b0, dmem_we = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0;
    logic [3:0]  dmem_be = '0;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        imem_ready, dmem_ready, dmem_err;

    int checks = 0;
    int failures = 0;

    rv_mem #(.DPWIDTH(32), .MEMWORDS(MW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // Each grant occupies the memory for W+2 edges; the response appears
    // after the edge W cycles past the grant edge.
    logic [31:0] mm [MW];
    bit          mk [MW];
    int unsigned ec = 0, resp_edge = 0, free_edge = 0;
    bit          have = 0, last_d = 0;
    bit          g_d, g_we, g_err;
    logic [3:0]  g_be;
    logic [31:0] g_addr, g_wd;
    bit          e_irdy = 0, e_drdy = 0, e_derr = 0;
    logic [31:0] ih = '0, dh = '0;
    bit          ihk = 1, dhk = 1;

    initial for (int i = 0; i < MW; i++) mk[i] = 0;

    always @(posedge clk) begin
        int idx;
        ec++;
        e_irdy = 0; e_drdy = 0; e_derr = 0;
        if (rst) begin
            have = 0; free_edge = 0; last_d = 0;
            ih = '0; ihk = 1; dh = '0; dhk = 1;
        end else begin
            if (!have && ec >= free_edge && (imem_req || dmem_req)) begin
                g_d    = dmem_req && (!imem_req || !last_d);
                last_d = g_d;
                g_addr = g_d ? dmem_addr : imem_addr;
                g_we   = g_d && dmem_we;
                g_be   = dmem_be;
                g_wd   = dmem_wdata;
                g_err  = (g_addr % 4 != 0) || ((g_addr / 4) >= MW);
                resp_edge = ec + W;
                free_edge = ec + W + 2;
                have = 1;
            end
            if (have && ec == resp_edge) begin
                idx = int'(g_addr / 4);
                if (g_d) begin
                    e_drdy = 1; e_derr = g_err;
                    if (g_err) begin
                        dh = '0; dhk = 1;
                    end else if (g_we) begin
                        for (int b = 0; b < 4; b++)
                            if (g_be[b]) mm[idx][8*b +: 8] = g_wd[8*b +: 8];
                        if (g_be == 4'hF) mk[idx] = 1;
                    end else begin
                        dh = mm[idx]; dhk = mk[idx];
                    end
                end else begin
                    e_irdy = 1;
                    if (g_err) begin
                        ih = 32'h0000_0013; ihk = 1;
                    end else begin
                        ih = mm[idx]; ihk = mk[idx];
                    end
                end
                have = 0;
            end
        end
    end

    // Every cycle out of reset: strobes, error and held read data.
    always @(negedge clk) begin
        if (!rst) begin
            chk("imem_ready", {31'b0, imem_ready}, {31'b0, e_irdy});
            chk("dmem_ready", {31'b0, dmem_ready}, {31'b0, e_drdy});
            if (e_drdy) chk("dmem_err", {31'b0, dmem_err}, {31'b0, e_derr});
            if (ihk) chk("imem_rdata", imem_rdata, ih);
            if (dhk) chk("dmem_rdata", dmem_rdata, dh);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(posedge clk); #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic dacc(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        dmem_req = 1'b1; dmem_we = we; dmem_be = be; dmem_addr = a; dmem_wdata = wd;
        lat = 0; rd = 'x; er = 1'bx;
        while (!dmem_ready && lat < 60) begin @(posedge clk); #1; lat++; end
        if (!dmem_ready) begin
            failures++; checks++;
            $display("FAIL dmem_timeout: got no ready, required ready within 60 cycles");
        end else begin
            rd = dmem_rdata; er = dmem_err;
        end
        dmem_req = 1'b0;
    endtask

    task automatic iacc(input logic [31:0] a, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        imem_req = 1'b1; imem_addr = a;
        lat = 0; rd = 'x;
        while (!imem_ready && lat < 60) begin @(posedge clk); #1; lat++; end
        if (!imem_ready) begin
            failures++; checks++;
            $display("FAIL imem_timeout: got no ready, required ready within 60 cycles");
        end else rd = imem_rdata;
        imem_req = 1'b0;
    endtask

    task automatic pair(input logic [31:0] ia, input logic [31:0] da,
                        output int li, output int ld, output logic [31:0] ir, output logic [31:0] dr);
        @(posedge clk); #1;
        imem_req = 1'b1; imem_addr = ia;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_be = 4'hF; dmem_addr = da;
        li = -1; ld = -1; ir = 'x; dr = 'x;
        for (int c = 1; c <= 60 && (imem_req || dmem_req); c++) begin
            @(posedge clk); #1;
            if (imem_req && imem_ready) begin li = c; ir = imem_rdata; imem_req = 1'b0; end
            if (dmem_req && dmem_ready) begin ld = c; dr = dmem_rdata; dmem_req = 1'b0; end
        end
        imem_req = 1'b0; dmem_req = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, MW - 1)) << 2;
        if (r == 0) return w | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(MW * 4) + (32'($urandom_range(0, 1000)) << 2);
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd, ir, dr;
        logic        er;
        int          lat, li, ld;
        bit          seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_ready", {31'b0, imem_ready}, 32'd0);
        chk("rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("rst_dmem_err",   {31'b0, dmem_err},   32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'd0);
        chk("rst_dmem_rdata", dmem_rdata, 32'd0);
        @(posedge clk); #3 rst = 1'b0;

        // Write then read back, with exact latency.
        dacc(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        chk("wr10_lat", 32'(lat), 32'(1 + W));
        chk("wr10_err", {31'b0, er}, 32'd0);
        dacc(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", {31'b0, er}, 32'd0);
        chk("rd10_lat", 32'(lat), 32'(1 + W));

        // Byte-enable merge.
        dacc(1'b1, 4'hF, 32'h40, 32'h1122_3344, rd, er, lat);
        dacc(1'b1, 4'b0101, 32'h40, 32'hAABB_CCDD, rd, er, lat);
        dacc(1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        chk("be0101_data", rd, 32'h11BB_33DD);
        dacc(1'b1, 4'h0, 32'h40, 32'hFFFF_FFFF, rd, er, lat);
        chk("be0_err", {31'b0, er}, 32'd0);
        dacc(1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        chk("be0_nochange", rd, 32'h11BB_33DD);

        // Conflicts: after reset data wins; an intervening data access makes
        // the next conflict go to instruction.
        do_reset();
        pair(32'h10, 32'h40, li, ld, ir, dr);
        chk("pair1_d_lat", 32'(ld), 32'(1 + W));
        chk("pair1_i_lat", 32'(li), 32'(3 + 2 * W));
        chk("pair1_i_data", ir, 32'hDEAD_BEEF);
        chk("pair1_d_data", dr, 32'h11BB_33DD);
        dacc(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        pair(32'h40, 32'h10, li, ld, ir, dr);
        chk("pair2_i_lat", 32'(li), 32'(1 + W));
        chk("pair2_d_lat", 32'(ld), 32'(3 + 2 * W));
        chk("pair2_i_data", ir, 32'h11BB_33DD);

        // Error accesses.
        dacc(1'b1, 4'hF, 32'h0, 32'h1234_5678, rd, er, lat);
        dacc(1'b0, 4'hF, 32'h6, 32'h0, rd, er, lat);
        chk("mis_err", {31'b0, er}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        dacc(1'b1, 4'hF, 32'(4 * MW), 32'hFFFF_FFFF, rd, er, lat);
        chk("oor_err", {31'b0, er}, 32'd1);
        chk("oor_rdata", rd, 32'd0);
        dacc(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
        chk("oor_nochange", rd, 32'h1234_5678);
        chk("oor_nochange_err", {31'b0, er}, 32'd0);
        iacc(32'h2, ir, lat);
        chk("imis_nop", ir, 32'h0000_0013);
        dacc(1'b0, 4'hF, 32'(4 * (MW - 1)), 32'h0, rd, er, lat);
        chk("last_word_err", {31'b0, er}, 32'd0);

        // Reset while a write to 0x20 is in flight.
        dacc(1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, rd, er, lat);
        @(posedge clk); #1;
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'hF; dmem_addr = 32'h20; dmem_wdata = 32'h5555_5555;
`ifdef RV_MEM_WAIT_EN
        @(posedge clk); #3;
`else
        #2;
`endif
        rst = 1'b1;
        seen = 0;
        repeat (2) begin @(negedge clk); seen |= (imem_ready | dmem_ready); end
        dmem_req = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        chk("abort_no_ready", {31'b0, seen}, 32'd0);
        chk("abort_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("abort_dmem_rdata", dmem_rdata, 32'd0);
        chk("abort_imem_rdata", imem_rdata, 32'd0);
        dacc(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lat);
        chk("abort_word", rd, 32'hCAFE_F00D);
        chk("abort_idle_lat", 32'(lat), 32'(1 + W));

        // Fill the array so random reads have known contents.
        for (int w = 0; w < MW; w++) dacc(1'b1, 4'hF, 32'(w * 4), $urandom, rd, er, lat);

        // Random two-port traffic; each master holds its request until ready.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (imem_req && imem_ready) imem_req = 1'b0;
            if (dmem_req && dmem_ready) dmem_req = 1'b0;
            if (!imem_req && $urandom_range(0, 2) == 0) begin
                imem_req = 1'b1; imem_addr = rnd_addr();
            end
            if (!dmem_req && $urandom_range(0, 2) == 0) begin
                dmem_req = 1'b1; dmem_we = 1'($urandom_range(0, 1));
                dmem_be = 4'($urandom); dmem_addr = rnd_addr(); dmem_wdata = $urandom;
            end
        end
        for (int c = 0; c < 100 && (imem_req || dmem_req); c++) begin
            @(posedge clk); #1;
            if (imem_req && imem_ready) imem_req = 1'b0;
            if (dmem_req && dmem_ready) dmem_req = 1'b0;
        end
        if (imem_req || dmem_req) begin
            failures++; checks++;
            $display("FAIL drain: got requests still pending, required all served within 100 cycles");
            imem_req = 1'b0; dmem_req = 1'b0;
        end
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
